// File: rtl/cpu_control_package.sv
// cpu_control_package: control encodings, stage bundle type and decode helpers for the core
package cpu_control_package;
  localparam int REG_W = 5;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_B
  } alu_function_t;
  typedef enum logic [2:0] {R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE} instruction_type_t;
  typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} forward_sel_t;
  typedef struct packed {
    alu_function_t     alu_control;
    logic              alu_select;
    instruction_type_t instruction_type;
    logic              dmem_write;
    logic              reg_write;
    logic              result_select;
    logic              branch;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic              valid;
  } ctrl_bundle_t;
  localparam ctrl_bundle_t BUBBLE = '0;
  // alt selects SUB for funct3=000 and arithmetic shift for funct3=101
  function automatic alu_function_t alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/control.sv
// control: single-instruction decoder producing ALU, format and strobe controls
module control
  import cpu_control_package::*;
(
  input  logic [31:0]       instruction,
  output alu_function_t     alu_control,
  output logic              alu_select,
  output instruction_type_t instruction_type,
  output logic              dmem_write,
  output logic              reg_write,
  output logic              result_select,
  output logic              branch
);
  logic [2:0] funct3;
  logic       unused_bits;
  assign funct3 = instruction[14:12];
  assign unused_bits = ^{instruction[31], instruction[29:25]};
  // opcode decode; unknown opcodes decode to a no-op with every strobe low
  always_comb begin
    alu_control = ALU_ADD;
    alu_select = 1'b0;
    instruction_type = R_TYPE;
    dmem_write = 1'b0;
    reg_write = 1'b0;
    result_select = 1'b0;
    branch = 1'b0;
    case (instruction[6:0])
      7'b0110011: begin
        reg_write = 1'b1;
        alu_control = alu_op(funct3, instruction[30]);
      end
      7'b0010011: begin
        reg_write = 1'b1;
        alu_select = 1'b1;
        instruction_type = I_TYPE;
        alu_control = alu_op(funct3, funct3 == 3'b101 && instruction[30]);
      end
      7'b0000011: begin
        reg_write = 1'b1;
        alu_select = 1'b1;
        result_select = 1'b1;
        instruction_type = I_TYPE;
      end
      7'b0100011: begin
        dmem_write = 1'b1;
        alu_select = 1'b1;
        instruction_type = S_TYPE;
      end
      7'b1100011: begin
        branch = 1'b1;
        alu_control = ALU_SUB;
        instruction_type = B_TYPE;
      end
      7'b0110111: begin
        reg_write = 1'b1;
        alu_select = 1'b1;
        alu_control = ALU_PASS_B;
        instruction_type = U_TYPE;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: staged control bundles with load-use/RAW stalls, forwarding select and branch flush
module pipeline_control
  import cpu_control_package::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit FORWARDING = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               id_instruction,
  input  logic                      id_valid,
  input  logic                      alu_equal,
  output logic                      stall,
  output logic                      flush,
  output logic                      pc_select,
  output forward_sel_t              forward_a,
  output forward_sel_t              forward_b,
  output alu_function_t             ex_alu_control,
  output logic                      ex_alu_select,
  output instruction_type_t         ex_instruction_type,
  output logic                      mem_dmem_write,
  output logic                      wb_reg_write,
  output logic                      wb_result_select,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd
);
  ctrl_bundle_t      id_b, ex_b, mem_b, wb_b;
  alu_function_t     d_alu;
  instruction_type_t d_type;
  logic              d_sel, d_dmem, d_reg, d_res, d_br, load_use, raw, unused_bits;
  control u_control (
    .instruction(id_instruction), .alu_control(d_alu), .alu_select(d_sel), .instruction_type(d_type),
    .dmem_write(d_dmem), .reg_write(d_reg), .result_select(d_res), .branch(d_br)
  );
  function automatic logic hit(input ctrl_bundle_t p, input logic [REG_W-1:0] r, input logic used);
    return used && p.valid && p.reg_write && p.rd != '0 && p.rd == r;
  endfunction
  function automatic logic any_hit(input ctrl_bundle_t p, input ctrl_bundle_t c);
    return hit(p, c.rs1, c.rs1_used) || hit(p, c.rs2, c.rs2_used);
  endfunction
  assign id_b = id_valid ? ctrl_bundle_t'{
    alu_control: d_alu, alu_select: d_sel, instruction_type: d_type, dmem_write: d_dmem,
    reg_write: d_reg, result_select: d_res, branch: d_br,
    rd: id_instruction[11:7], rs1: id_instruction[19:15], rs2: id_instruction[24:20],
    rs1_used: d_type != U_TYPE && d_type != J_TYPE, rs2_used: d_type inside {R_TYPE, S_TYPE, B_TYPE},
    valid: 1'b1} : BUBBLE;
  // hazards and forwarding from current stage contents; the older branch beats any stall
  always_comb begin
    load_use = ex_b.result_select && any_hit(ex_b, id_b);
    raw = !FORWARDING && (any_hit(ex_b, id_b) || any_hit(mem_b, id_b) || any_hit(wb_b, id_b));
    flush = ex_b.valid && ex_b.branch && alu_equal;
    stall = !flush && (load_use || raw);
    forward_a = !FORWARDING ? FWD_REG : hit(mem_b, ex_b.rs1, ex_b.rs1_used) ? FWD_MEM :
                hit(wb_b, ex_b.rs1, ex_b.rs1_used) ? FWD_WB : FWD_REG;
    forward_b = !FORWARDING ? FWD_REG : hit(mem_b, ex_b.rs2, ex_b.rs2_used) ? FWD_MEM :
                hit(wb_b, ex_b.rs2, ex_b.rs2_used) ? FWD_WB : FWD_REG;
  end
  // EX takes a bubble on stall or flush; MEM and WB always advance
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_b <= BUBBLE;
      mem_b <= BUBBLE;
      wb_b <= BUBBLE;
    end else begin
      ex_b <= (stall || flush) ? BUBBLE : id_b;
      mem_b <= ex_b;
      wb_b <= mem_b;
    end
  end
  assign pc_select = flush;
  assign ex_alu_control = ex_b.alu_control;
  assign ex_alu_select = ex_b.alu_select;
  assign ex_instruction_type = ex_b.instruction_type;
  assign mem_dmem_write = mem_b.valid && mem_b.dmem_write;
  assign wb_reg_write = wb_b.valid && wb_b.reg_write;
  assign wb_result_select = wb_b.result_select;
  assign wb_rd = REG_ADDR_WIDTH'(wb_b.rd);
  assign unused_bits = ^wb_b;
endmodule
